// File: rtl/exec_unit_if.sv
// Execute-stage bundle: request side (opcode, operands, destination) and the
// write-back side (strobe, address, data, flags) that feeds the register file.
interface exec_unit_if #(
  parameter int DataBusWidth = 8,
  parameter int AddrBusWidth = 2
);
  logic                    start;
  logic [2:0]              op;
  logic [DataBusWidth-1:0] opA;
  logic [DataBusWidth-1:0] opB;
  logic [AddrBusWidth-1:0] dstAddr;
  logic                    busy;
  logic                    wbLoad;
  logic [AddrBusWidth-1:0] wbAddr;
  logic [DataBusWidth-1:0] wbData;
  logic                    carry;
  logic                    zero;

  modport master (
    output start, op, opA, opB, dstAddr,
    input  busy, wbLoad, wbAddr, wbData, carry, zero
  );

  modport slave (
    input  start, op, opA, opB, dstAddr,
    output busy, wbLoad, wbAddr, wbData, carry, zero
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus iterative shift-add multiply and
// bit-serial left shift, returning a one-cycle registered write-back pulse.
module exec_unit #(
  parameter int DataBusWidth = 8,
  parameter int AddrBusWidth = 2
) (
  input logic        clk,
  input logic        rst,
  exec_unit_if.slave io_eu
);
  localparam int W  = DataBusWidth;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_SHIFT = 2'd2,
    S_WB    = 2'd3
  } state_t;

  function automatic logic f_is_zero(input logic [W-1:0] v);
    return (v == {W{1'b0}});
  endfunction

  state_t                  r_state, w_state_nxt;
  logic [AddrBusWidth-1:0] r_dst, w_dst_nxt;
  logic [2*W-1:0]          r_acc, w_acc_nxt;
  logic [2*W-1:0]          r_mcand, w_mcand_nxt;
  logic [2*W-1:0]          w_acc_add;
  logic [W-1:0]            r_mplier, w_mplier_nxt;
  logic [W-1:0]            r_sh, w_sh_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [W:0]              w_sum, w_diff;
  logic                    w_fin;
  logic [W-1:0]            w_fin_res;
  logic                    w_fin_c;

  logic                    r_busy;
  logic                    r_wb_load;
  logic [AddrBusWidth-1:0] r_wb_addr;
  logic [W-1:0]            r_wb_data;
  logic                    r_carry;
  logic                    r_zero;

  assign io_eu.busy   = r_busy;
  assign io_eu.wbLoad = r_wb_load;
  assign io_eu.wbAddr = r_wb_addr;
  assign io_eu.wbData = r_wb_data;
  assign io_eu.carry  = r_carry;
  assign io_eu.zero   = r_zero;

  // Next-state and datapath: w_fin marks the edge that loads the write-back registers.
  always_comb begin
    w_state_nxt  = r_state;
    w_dst_nxt    = r_dst;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_sh_nxt     = r_sh;
    w_cnt_nxt    = r_cnt;
    w_fin        = 1'b0;
    w_fin_res    = {W{1'b0}};
    w_fin_c      = 1'b0;
    w_sum        = {1'b0, io_eu.opA} + {1'b0, io_eu.opB};
    w_diff       = {1'b0, io_eu.opA} - {1'b0, io_eu.opB};
    w_acc_add    = r_acc + (r_mplier[0] ? r_mcand : {(2*W){1'b0}});

    case (r_state)
      S_IDLE: begin
        if (io_eu.start) begin
          w_dst_nxt   = io_eu.dstAddr;
          w_fin       = 1'b1;
          w_state_nxt = S_WB;
          case (io_eu.op)
            OP_ADD: begin
              w_fin_res = w_sum[W-1:0];
              w_fin_c   = w_sum[W];
            end
            OP_SUB: begin
              w_fin_res = w_diff[W-1:0];
              w_fin_c   = w_diff[W];
            end
            OP_AND: w_fin_res = io_eu.opA & io_eu.opB;
            OP_OR:  w_fin_res = io_eu.opA | io_eu.opB;
            OP_XOR: w_fin_res = io_eu.opA ^ io_eu.opB;
            OP_MOV: w_fin_res = io_eu.opB;
            OP_MUL: begin
              w_fin        = 1'b0;
              w_acc_nxt    = {(2*W){1'b0}};
              w_mcand_nxt  = {{W{1'b0}}, io_eu.opA};
              w_mplier_nxt = io_eu.opB;
              w_cnt_nxt    = CW'(W);
              w_state_nxt  = S_MUL;
            end
            OP_SHL: begin
              if (io_eu.opB[2:0] == 3'b000) begin
                w_fin_res = io_eu.opA;
              end else begin
                w_fin       = 1'b0;
                w_sh_nxt    = io_eu.opA;
                w_cnt_nxt   = CW'(io_eu.opB[2:0]);
                w_state_nxt = S_SHIFT;
              end
            end
            default: w_fin_res = {W{1'b0}};
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        // One multiplier bit per cycle; the last iteration feeds w_acc_add straight to write-back.
        w_acc_nxt    = w_acc_add;
        w_mcand_nxt  = {r_mcand[2*W-2:0], 1'b0};
        w_mplier_nxt = {1'b0, r_mplier[W-1:1]};
        w_cnt_nxt    = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_fin       = 1'b1;
          w_fin_res   = w_acc_add[W-1:0];
          w_fin_c     = |w_acc_add[2*W-1:W];
          w_state_nxt = S_WB;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
      S_SHIFT: begin
        w_sh_nxt  = {r_sh[W-2:0], 1'b0};
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_fin       = 1'b1;
          w_fin_res   = {r_sh[W-2:0], 1'b0};
          w_fin_c     = r_sh[W-1];
          w_state_nxt = S_WB;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered write-back outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dst     <= {AddrBusWidth{1'b0}};
      r_acc     <= {(2*W){1'b0}};
      r_mcand   <= {(2*W){1'b0}};
      r_mplier  <= {W{1'b0}};
      r_sh      <= {W{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_busy    <= 1'b0;
      r_wb_load <= 1'b0;
      r_wb_addr <= {AddrBusWidth{1'b0}};
      r_wb_data <= {W{1'b0}};
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dst     <= w_dst_nxt;
      r_acc     <= w_acc_nxt;
      r_mcand   <= w_mcand_nxt;
      r_mplier  <= w_mplier_nxt;
      r_sh      <= w_sh_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_wb_load <= w_fin;
      if (w_fin) begin
        r_wb_addr <= w_dst_nxt;
        r_wb_data <= w_fin_res;
        r_carry   <= w_fin_c;
        r_zero    <= f_is_zero(w_fin_res);
      end
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: the driver pushes expected write-backs from an
// arithmetic reference model, a negedge monitor pops and compares them.
module tb_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_unit_if #(.DataBusWidth(8), .AddrBusWidth(2)) bus ();
  exec_unit #(.DataBusWidth(8), .AddrBusWidth(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_eu (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] addr;
    logic       c;
    logic       z;
    int         lat;
    int         cap;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         busy_run = 0;
  logic       rst_edge = 1'b0;
  logic       have_last = 1'b0;
  logic       expect_low = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [1:0] last_addr = 2'd0;
  logic       last_c = 1'b0;
  logic       last_z = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode's definition.
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] d);
    exp_t e;
    int   r;
    int   k;
    e.addr = d;
    e.lat  = 1;
    e.c    = 1'b0;
    e.cap  = 0;
    case (op)
      3'd0: begin r = a + b; e.c = (r > 255); end
      3'd1: begin r = a - b; e.c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = b;
      3'd6: begin r = a * b; e.c = (r[15:8] != 8'h00); e.lat = 9; end
      default: begin
        k = b % 8;
        r = a << k;
        e.c = (k != 0) ? r[8] : 1'b0;
        e.lat = 1 + k;
      end
    endcase
    e.data = r[7:0];
    e.z    = (e.data == 8'h00);
    return e;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  // Monitor: reset checks, scoreboard pops on wbLoad, hold checks otherwise.
  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_run = busy_run + 1;
    else busy_run = 0;
    if (rst_edge) begin
      chk("reset_busy",   32'(bus.busy),   32'd0);
      chk("reset_wbLoad", 32'(bus.wbLoad), 32'd0);
      chk("reset_wbAddr", 32'(bus.wbAddr), 32'd0);
      chk("reset_wbData", 32'(bus.wbData), 32'd0);
      chk("reset_carry",  32'(bus.carry),  32'd0);
      chk("reset_zero",   32'(bus.zero),   32'd0);
      have_last  = 1'b1;
      last_data  = 8'h00;
      last_addr  = 2'd0;
      last_c     = 1'b0;
      last_z     = 1'b0;
      expect_low = 1'b0;
    end else if (bus.wbLoad === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_wb: wbLoad with no pending op, addr=%0d data=0x%0h", bus.wbAddr, bus.wbData);
      end else begin
        mon_e = q.pop_front();
        chk("wb_data",     32'(bus.wbData), 32'(mon_e.data));
        chk("wb_addr",     32'(bus.wbAddr), 32'(mon_e.addr));
        chk("wb_carry",    32'(bus.carry),  32'(mon_e.c));
        chk("wb_zero",     32'(bus.zero),   32'(mon_e.z));
        chk("latency",     32'(cyc - mon_e.cap + 1), 32'(mon_e.lat));
        chk("busy_cycles", 32'(busy_run), 32'(mon_e.lat));
        last_data  = mon_e.data;
        last_addr  = mon_e.addr;
        last_c     = mon_e.c;
        last_z     = mon_e.z;
        have_last  = 1'b1;
        expect_low = 1'b1;
      end
    end else begin
      if (have_last) begin
        chk("hold_data",  32'(bus.wbData), 32'(last_data));
        chk("hold_addr",  32'(bus.wbAddr), 32'(last_addr));
        chk("hold_carry", 32'(bus.carry),  32'(last_c));
        chk("hold_zero",  32'(bus.zero),   32'(last_z));
      end
      if (expect_low) begin
        chk("busy_after_wb", 32'(bus.busy), 32'd0);
        expect_low = 1'b0;
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] d, input bit expect_wb);
    exp_t e;
    int   guard;
    guard = 0;
    while (bus.busy !== 1'b0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: busy still high after %0d cycles", guard);
    end
    bus.start   = 1'b1;
    bus.op      = op;
    bus.opA     = a;
    bus.opB     = b;
    bus.dstAddr = d;
    @(posedge clk);
    #1;
    if (expect_wb) begin
      e     = model(op, a, b, d);
      e.cap = cyc;
      q.push_back(e);
    end
    bus.start   = 1'b0;
    bus.op      = 3'($urandom);
    bus.opA     = 8'($urandom);
    bus.opB     = 8'($urandom);
    bus.dstAddr = 2'($urandom);
  endtask

  initial begin
    bus.start   = 1'b1;
    bus.op      = 3'd0;
    bus.opA     = 8'h12;
    bus.opB     = 8'h34;
    bus.dstAddr = 2'd1;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;

    do_op(3'd0, 8'hFF, 8'h01, 2'd2, 1'b1);
    do_op(3'd1, 8'h10, 8'h20, 2'd1, 1'b1);
    do_op(3'd6, 8'h0D, 8'h13, 2'd3, 1'b1);
    do_op(3'd6, 8'h10, 8'h10, 2'd0, 1'b1);
    do_op(3'd7, 8'h81, 8'h01, 2'd1, 1'b1);
    do_op(3'd7, 8'h81, 8'h00, 2'd2, 1'b1);
    do_op(3'd7, 8'h01, 8'h07, 2'd3, 1'b1);

    // A start pulse while MUL is busy must be dropped, not queued.
    do_op(3'd6, 8'hA5, 8'h3C, 2'd1, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    bus.start   = 1'b1;
    bus.op      = 3'd0;
    bus.opA     = 8'($urandom);
    bus.opB     = 8'($urandom);
    bus.dstAddr = 2'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;

    // Reset sampled in the fourth MUL cycle: no write-back may appear.
    do_op(3'd6, 8'h77, 8'h99, 2'd2, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_op(3'd0, 8'h40, 8'h02, 2'd3, 1'b1);

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 2'($urandom), 1'b1);
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
